periph_bus_bridge: RTL and testbench
====================================

Name: periph_bus_bridge

Overview:
- Sits between the CPU memory stage and the memory-mapped peripherals (timer and siblings).
- Accepts one request at a time and pre-checks it for invalid, misaligned and out-of-bounds accesses.
- Issues valid requests to exactly one peripheral slot for one cycle, waits a fixed latency, then returns the registered response to the CPU.
- Peripherals need no valid/ready logic.

Parameters:
- ADDR_BASE, 0, byte address of slot 0.
- N_SLOTS, 4, number of peripheral slots (power of two, ≤ 8).
- SLOT_BYTES, 32, bytes per slot (power of two; 8 words).
- PERIPH_LAT, 1, cycles from issue edge to peripheral response valid (1..7).

Ports:
- clk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  bridge idle, can accept.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wr_data  in  WORD_W  write data.
- i_req_wr_en  in  1  1 = write.
- i_req_count  in  MEM_COUNT_W  access size (NONE/BYTE/HALF/WORD).
- o_res_valid  out  1  one-cycle response strobe.
- o_res_rd_data  out  WORD_W  read data.
- o_res_code  out  MEM_CODE_W  OK/INVALID/MISALIGNED/OUT_OF_BOUNDS.
- o_per_addr  out  ADDR_W  latched address.
- o_per_wr_data  out  WORD_W  latched write data.
- o_per_wr_en  out  1  write strobe, ISSUE only.
- o_per_count  out  MEM_COUNT_W  latched count in ISSUE, MEM_COUNT_NONE otherwise.
- o_per_sel  out  N_SLOTS  one-hot slot select, ISSUE only.
- i_per_rd_data  in  N_SLOTS*WORD_W  packed slot read data, slot k at [k*WORD_W +: WORD_W].
- i_per_res_code  in  N_SLOTS*MEM_CODE_W  packed slot response codes.

Behaviour:
- Reset (async, active-high), all outputs: state IDLE, o_req_ready=1, o_res_valid=0, o_res_rd_data=0, o_res_code=OK, o_per_sel=0, o_per_wr_en=0, o_per_count=NONE, o_per_addr=0, o_per_wr_data=0. Reset mid-transaction aborts silently; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch addr/data/wr_en/count. Checks in priority order:
  1. count==NONE → INVALID.
  2. WORD with addr[1:0]!=0, or HALF with addr[0]=1 → MISALIGNED.
  3. addr<ADDR_BASE or addr≥ADDR_BASE+N_SLOTS*SLOT_BYTES → OUT_OF_BOUNDS.
  - Any error → RESP with that code, rd_data=0; no peripheral strobe.
  - Otherwise slot=(addr-ADDR_BASE)/SLOT_BYTES latched → ISSUE.
- ISSUE (1 cycle): o_per_sel[slot]=1; o_per_wr_en=latched wr_en; o_per_count=latched count. Load counter=PERIPH_LAT → WAIT.
- WAIT: peripheral outputs idle. Counter decrements each cycle. When counter==1, capture slot's rd_data and code into the response registers → RESP.
- RESP (1 cycle): o_res_valid=1 → IDLE. o_res_rd_data/o_res_code hold their values until the next RESP.
- o_req_ready=0 in ISSUE, WAIT and RESP. A request presented on the RESP cycle is not accepted; it is accepted in the following IDLE cycle.
- Latency, with acceptance edge = cycle 0:
  - error response o_res_valid in cycle 1;
  - peripheral response o_res_valid in cycle 2+PERIPH_LAT.
- The response has no back-pressure; upstream must take it.
- Throughput: one transaction in flight.
- Address arithmetic uses ADDR_W-bit unsigned compares. The top-of-range compare is computed at ADDR_W+1 bits, so a range ending at 2^ADDR_W does not wrap.

Optional Feature:
- BUS_ERR_CAPTURE_EN. When defined, adds outputs o_err_valid (1) and o_err_addr (ADDR_W) and input i_err_clr (1).
  - The first non-OK response (bridge- or peripheral-generated) latches its address and sets o_err_valid.
  - Later errors do not overwrite it (sticky).
  - i_err_clr clears it. If clear and an error occur in the same cycle, the new error wins.
  - Reset clears both outputs.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package/config.vh holds:
  - ADDR_W, WORD_W, MEM_COUNT_W, MEM_COUNT_NONE/BYTE/HALF/WORD;
  - MEM_CODE_W=2;
  - MEM_CODE_OK=0, MEM_CODE_INVALID=1, MEM_CODE_MISALIGNED=2, MEM_CODE_OUT_OF_BOUNDS=3;
  - FSM state encodings.
- One natural sub-module: mem_req_check, purely combinational. It takes addr, count and range parameters and returns the error code and slot index. The timer and future peripherals reuse it.

Test Plan:
- Word read at ADDR_BASE+0x24 (slot 1), PERIPH_LAT=1, slot 1 returns 0xDEADBEEF/OK → o_per_sel=4'b0010 in cycle 1, o_res_valid in cycle 3 with 0xDEADBEEF, OK.
- Word write to addr 0x02 → MISALIGNED in cycle 1, o_per_sel never asserted. Half to 0x03 → MISALIGNED. Byte to 0x03 → issued.
- Read at ADDR_BASE+128 with N_SLOTS=4, SLOT_BYTES=32 → OUT_OF_BOUNDS. count=NONE at a valid address → INVALID (takes priority over misalignment).
- PERIPH_LAT=3 → o_res_valid exactly in cycle 5. Back-to-back requests with i_req_valid held high → second accepted in the cycle after RESP.
- areset pulsed during WAIT → outputs return to reset values immediately, no o_res_valid. The next request completes normally.
- With BUS_ERR_CAPTURE_EN: misaligned read at 0x06, then out-of-bounds at 0x200 → o_err_addr=0x06 (sticky). i_err_clr → o_err_valid=0.

Source files
------------

// File: rtl/periph_bus_bridge_pkg.sv
// rtl/periph_bus_bridge_pkg.sv - shared widths, access sizes, response codes and FSM states
package periph_bus_bridge_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK            = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_req_check.sv
// rtl/mem_req_check.sv - combinational request pre-check: validity, alignment, range and slot decode
module mem_req_check
  import periph_bus_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE  = '0,
  parameter int                N_SLOTS    = 4,
  parameter int                SLOT_BYTES = 32,
  localparam int               SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [MEM_COUNT_W-1:0] count_i,
  output logic [MEM_CODE_W-1:0]  code_o,
  output logic [SLOT_W-1:0]      slot_o
);

  localparam int SLOT_SH = $clog2(SLOT_BYTES);
  // One extra bit so a window ending exactly at 2^ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0] RANGE_END =
    {1'b0, ADDR_BASE} + (ADDR_W+1)'(N_SLOTS * SLOT_BYTES);

  logic [ADDR_W:0] diff;

  always_comb begin
    diff   = {1'b0, addr_i} - {1'b0, ADDR_BASE};
    slot_o = SLOT_W'(diff >> SLOT_SH);
    code_o = MEM_CODE_OK;
    if (count_i == MEM_COUNT_NONE) begin
      code_o = MEM_CODE_INVALID;
    end else if ((count_i == MEM_COUNT_WORD && addr_i[1:0] != 2'b00) ||
                 (count_i == MEM_COUNT_HALF && addr_i[0])) begin
      code_o = MEM_CODE_MISALIGNED;
    end else if (diff[ADDR_W] || ({1'b0, addr_i} >= RANGE_END)) begin
      code_o = MEM_CODE_OUT_OF_BOUNDS;
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// rtl/periph_bus_bridge.sv - CPU to peripheral-slot bridge; optional BUS_ERR_CAPTURE_EN adds sticky error address capture
module periph_bus_bridge
  import periph_bus_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE  = '0,
  parameter int                N_SLOTS    = 4,
  parameter int                SLOT_BYTES = 32,
  parameter int                PERIPH_LAT = 1
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic [WORD_W-1:0]             i_req_wr_data,
  input  logic                          i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0]        i_req_count,
  output logic                          o_res_valid,
  output logic [WORD_W-1:0]             o_res_rd_data,
  output logic [MEM_CODE_W-1:0]         o_res_code,
  output logic [ADDR_W-1:0]             o_per_addr,
  output logic [WORD_W-1:0]             o_per_wr_data,
  output logic                          o_per_wr_en,
  output logic [MEM_COUNT_W-1:0]        o_per_count,
  output logic [N_SLOTS-1:0]            o_per_sel,
  input  logic [N_SLOTS*WORD_W-1:0]     i_per_rd_data,
  input  logic [N_SLOTS*MEM_CODE_W-1:0] i_per_res_code
`ifdef BUS_ERR_CAPTURE_EN
  ,
  input  logic                          i_err_clr,
  output logic                          o_err_valid,
  output logic [ADDR_W-1:0]             o_err_addr
`endif
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]      wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic [MEM_COUNT_W-1:0] count_q, count_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [WORD_W-1:0]      res_data_q, res_data_d;
  logic [MEM_CODE_W-1:0]  res_code_q, res_code_d;

  logic [MEM_CODE_W-1:0]  chk_code;
  logic [SLOT_W-1:0]      chk_slot;

  mem_req_check #(
    .ADDR_BASE  (ADDR_BASE),
    .N_SLOTS    (N_SLOTS),
    .SLOT_BYTES (SLOT_BYTES)
  ) u_check (
    .addr_i  (i_req_addr),
    .count_i (i_req_count),
    .code_o  (chk_code),
    .slot_o  (chk_slot)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      count_q    <= MEM_COUNT_NONE;
      slot_q     <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_code_q <= MEM_CODE_OK;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      count_q    <= count_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_code_q <= res_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    count_d     = count_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_code_d  = res_code_q;
    o_req_ready = 1'b0;
    o_res_valid = 1'b0;
    o_per_sel   = '0;
    o_per_wr_en = 1'b0;
    o_per_count = MEM_COUNT_NONE;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          addr_d    = i_req_addr;
          wr_data_d = i_req_wr_data;
          wr_en_d   = i_req_wr_en;
          count_d   = i_req_count;
          if (chk_code != MEM_CODE_OK) begin
            res_code_d = chk_code;
            res_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            slot_d  = chk_slot;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        o_per_sel   = N_SLOTS'(1) << slot_q;
        o_per_wr_en = wr_en_q;
        o_per_count = count_q;
        cnt_d       = 3'(PERIPH_LAT);
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          res_data_d = i_per_rd_data[slot_q*WORD_W +: WORD_W];
          res_code_d = i_per_res_code[slot_q*MEM_CODE_W +: MEM_CODE_W];
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        o_res_valid = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_res_rd_data = res_data_q;
  assign o_res_code    = res_code_q;
  assign o_per_addr    = addr_q;
  assign o_per_wr_data = wr_data_q;

`ifdef BUS_ERR_CAPTURE_EN
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_event;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // A clear coinciding with a new error lets the new error take the slot.
  always_comb begin
    err_event   = (state_q == ST_RESP) && (res_code_q != MEM_CODE_OK);
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (i_err_clr) err_valid_d = 1'b0;
    if (err_event && (!err_valid_q || i_err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = addr_q;
    end
  end

  assign o_err_valid = err_valid_q;
  assign o_err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_periph_bus_bridge.sv
// tb/tb_periph_bus_bridge.sv - randomized self-checking bench for periph_bus_bridge
module tb_periph_bus_bridge;

  localparam int          ADDR_W = 32;
  localparam int          WORD_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          NS     = 4;
  localparam int          SB     = 32;
  localparam int          LAT    = 3;

  logic                 clk = 1'b0;
  logic                 areset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr = '0;
  logic [WORD_W-1:0]    req_wr_data = '0;
  logic                 req_wr_en = 1'b0;
  logic [1:0]           req_count = 2'd0;
  logic                 res_valid;
  logic [WORD_W-1:0]    res_rd_data;
  logic [1:0]           res_code;
  logic [ADDR_W-1:0]    per_addr;
  logic [WORD_W-1:0]    per_wr_data;
  logic                 per_wr_en;
  logic [1:0]           per_count;
  logic [NS-1:0]        per_sel;
  logic [NS*WORD_W-1:0] per_rd_data = '0;
  logic [NS*2-1:0]      per_res_code = '0;
`ifdef BUS_ERR_CAPTURE_EN
  logic                 err_clr = 1'b0;
  logic                 err_valid;
  logic [ADDR_W-1:0]    err_addr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  periph_bus_bridge #(
    .ADDR_BASE  (BASE),
    .N_SLOTS    (NS),
    .SLOT_BYTES (SB),
    .PERIPH_LAT (LAT)
  ) dut (
    .clk            (clk),
    .areset         (areset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wr_data),
    .i_req_wr_en    (req_wr_en),
    .i_req_count    (req_count),
    .o_res_valid    (res_valid),
    .o_res_rd_data  (res_rd_data),
    .o_res_code     (res_code),
    .o_per_addr     (per_addr),
    .o_per_wr_data  (per_wr_data),
    .o_per_wr_en    (per_wr_en),
    .o_per_count    (per_count),
    .o_per_sel      (per_sel),
    .i_per_rd_data  (per_rd_data),
    .i_per_res_code (per_res_code)
`ifdef BUS_ERR_CAPTURE_EN
    ,
    .i_err_clr      (err_clr),
    .o_err_valid    (err_valid),
    .o_err_addr     (err_addr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules: 0 = issue to slot, else the bridge's own error code.
  function automatic void ref_check(input logic [31:0] a, input logic [1:0] c,
                                    output logic [1:0] code, output int slot);
    longint ua  = longint'(a);
    longint top = longint'(BASE) + NS * SB;
    slot = 0;
    if (c == 2'd0) code = 2'd1;
    else if ((c == 2'd3 && ua % 4 != 0) || (c == 2'd2 && ua % 2 != 0)) code = 2'd2;
    else if (ua < longint'(BASE) || ua >= top) code = 2'd3;
    else begin
      code = 2'd0;
      slot = int'((ua - longint'(BASE)) / SB);
    end
  endfunction

  task automatic randomize_periphs();
    for (int k = 0; k < NS; k++) begin
      per_rd_data[k*WORD_W +: WORD_W] = $urandom;
      per_res_code[k*2 +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input logic [1:0] c, input bit rnd_per);
    logic [1:0]  bcode;
    int          slot;
    logic [31:0] edata;
    logic [1:0]  ecode;
    int          elat;
    int          lat;
    logic [NS-1:0] sel1, other_sel;
    logic        wr1;
    logic [1:0]  cnt1;
    if (rnd_per) randomize_periphs();
    ref_check(a, c, bcode, slot);
    if (bcode == 2'd0) begin
      edata = per_rd_data[slot*WORD_W +: WORD_W];
      ecode = per_res_code[slot*2 +: 2];
      elat  = 2 + LAT;
    end else begin
      edata = 32'h0;
      ecode = bcode;
      elat  = 1;
    end
    @(negedge clk);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_wr_en = wr; req_wr_data = wd; req_count = c;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; sel1 = '0; other_sel = '0; wr1 = 1'b0; cnt1 = 2'd0;
    while (!res_valid && lat < 20) begin
      if (lat == 1) begin
        sel1 = per_sel; wr1 = per_wr_en; cnt1 = per_count;
      end else begin
        other_sel |= per_sel;
      end
      @(negedge clk);
      lat++;
    end
    other_sel |= per_sel;
    check("latency", 64'(lat), 64'(elat));
    check("rd_data", 64'(res_rd_data), 64'(edata));
    check("code", 64'(res_code), 64'(ecode));
    check("ready_resp", 64'(req_ready), 64'd0);
    check("per_addr", 64'(per_addr), 64'(a));
    check("sel_issue", 64'(sel1), (bcode == 2'd0) ? (64'd1 << slot) : 64'd0);
    check("sel_other", 64'(other_sel), 64'd0);
    if (bcode == 2'd0) begin
      check("issue_wr_en", 64'(wr1), 64'(wr));
      check("issue_count", 64'(cnt1), 64'(c));
      check("per_wr_data", 64'(per_wr_data), 64'(wd));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_rd_data), 64'd0);
    check({tag, "_res_code"}, 64'(res_code), 64'd0);
    check({tag, "_per_sel"}, 64'(per_sel), 64'd0);
    check({tag, "_per_wr_en"}, 64'(per_wr_en), 64'd0);
    check({tag, "_per_count"}, 64'(per_count), 64'd0);
    check({tag, "_per_addr"}, 64'(per_addr), 64'd0);
    check({tag, "_per_wr_data"}, 64'(per_wr_data), 64'd0);
  endtask

  initial begin
    int t, first, second;
    bit seen;
    logic [31:0] a;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    areset = 1'b0;

    // Directed cases from the rules, then random traffic.
    per_rd_data[1*WORD_W +: WORD_W] = 32'hDEADBEEF;
    per_res_code[1*2 +: 2] = 2'd0;
    run_txn(BASE + 32'h24, 1'b0, 32'h0, 2'd3, 1'b0);
    run_txn(32'h02, 1'b1, 32'h1234, 2'd3, 1'b1);
    run_txn(32'h03, 1'b0, 32'h0, 2'd2, 1'b1);
    run_txn(32'h03, 1'b1, 32'hA5, 2'd1, 1'b1);
    run_txn(BASE + 32'd128, 1'b0, 32'h0, 2'd3, 1'b1);
    run_txn(32'h08, 1'b0, 32'h0, 2'd0, 1'b1);
    run_txn(32'h01, 1'b0, 32'h0, 2'd0, 1'b1);
    run_txn(BASE + 32'h7C, 1'b1, 32'h55AA, 2'd3, 1'b1);
    run_txn(32'hFFFF_FFFC, 1'b0, 32'h0, 2'd3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 150));
      run_txn(a, 1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'b1);
    end

    // Back-to-back with valid held high.
    randomize_periphs();
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'h40; req_wr_en = 1'b0; req_count = 2'd3;
    first = 0; second = 0; t = 0;
    while (second == 0 && t < 40) begin
      @(negedge clk);
      t++;
      if (res_valid) begin
        if (first == 0) begin
          first = t;
          check("b2b_ready_resp", 64'(req_ready), 64'd0);
        end else begin
          second = t;
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_first", 64'(first), 64'(2 + LAT));
    check("b2b_second", 64'(second), 64'(2 * (2 + LAT) + 1));

    // Reset pulse in WAIT aborts without a response.
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'h44; req_count = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 areset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    areset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= res_valid;
    end
    check("midreset_no_resp", 64'(seen), 64'd0);
    run_txn(BASE + 32'h48, 1'b0, 32'h0, 2'd3, 1'b1);

`ifdef BUS_ERR_CAPTURE_EN
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("err_cleared0", 64'(err_valid), 64'd0);
    run_txn(32'h06, 1'b0, 32'h0, 2'd3, 1'b1);
    run_txn(32'h200, 1'b0, 32'h0, 2'd3, 1'b1);
    @(negedge clk);
    check("err_valid", 64'(err_valid), 64'd1);
    check("err_addr", 64'(err_addr), 64'h06);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("err_cleared", 64'(err_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
